// File: rtl/mini16_reset_seq_if.sv
// ---------------------------------------------------------------------------
// mini16_reset_seq_if
//
// Bundles the control inputs and reset outputs of the mini16 reset sequencer.
// The clock and board reset stay outside the interface as plain ports.
//
// Signals:
//   sw_reset_req  single-cycle request to re-run the reset sequence
//   wdt_enable    watchdog counts only while high
//   wdt_kick      clears the watchdog counter
//   wdt_limit     watchdog expiry count, 0 disables expiry
//   rst_out       active-high channel resets, bit 0 released first
//   all_released  high when every rst_out bit is 0
//   wdt_fired     one-cycle pulse on watchdog expiry
//   cause         last sequence cause: 0 power-on, 1 software, 2 watchdog
//
// Modports:
//   master  the side that requests resets and consumes the reset outputs
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface mini16_reset_seq_if #(
   parameter int CHANNELS  = 4,
   parameter int WDT_WIDTH = 16
);

   logic                 sw_reset_req;
   logic                 wdt_enable;
   logic                 wdt_kick;
   logic [WDT_WIDTH-1:0] wdt_limit;
   logic [CHANNELS-1:0]  rst_out;
   logic                 all_released;
   logic                 wdt_fired;
   logic [1:0]           cause;

   modport master (
      output sw_reset_req,
      output wdt_enable,
      output wdt_kick,
      output wdt_limit,
      input  rst_out,
      input  all_released,
      input  wdt_fired,
      input  cause
   );

   modport slave (
      input  sw_reset_req,
      input  wdt_enable,
      input  wdt_kick,
      input  wdt_limit,
      output rst_out,
      output all_released,
      output wdt_fired,
      output cause
   );

endinterface

// File: rtl/mini16_reset_seq.sv
// ---------------------------------------------------------------------------
// mini16_reset_seq
//
// Reset sequencer for mini16 SoC builds. One asynchronous active-low board
// reset is turned into CHANNELS active-high reset outputs that are held for
// HOLD_CYCLES after the sequence starts and then released one by one,
// STAGGER cycles apart, bit 0 first. A software request or a watchdog
// expiry re-runs the whole sequence.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low board reset
//   bus    mini16_reset_seq_if.slave
//            in : sw_reset_req, wdt_enable, wdt_kick, wdt_limit
//            out: rst_out, all_released, wdt_fired, cause
//
// Release timing: rst_out[k] falls SYNC_STAGES + HOLD_CYCLES + k*STAGGER
// rising edges after the board reset goes high. Every output comes straight
// from a flop so downstream blocks can use them as asynchronous resets.
// ---------------------------------------------------------------------------
module mini16_reset_seq #(
   parameter int CHANNELS    = 4,
   parameter int HOLD_CYCLES = 10,
   parameter int STAGGER     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int WDT_WIDTH   = 16
) (
   input  logic             clk,
   input  logic             reset,
   mini16_reset_seq_if.slave bus
);

   // Offset from the start of the release phase to the last channel release.
   localparam int LAST_REL = (CHANNELS - 1) * STAGGER;
   // The sequence counter must reach both HOLD_CYCLES-1 and LAST_REL.
   localparam int CNT_MAX  = (HOLD_CYCLES > LAST_REL + 1) ? HOLD_CYCLES : LAST_REL + 1;
   localparam int CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);

   localparam logic [1:0] CAUSE_POWER_ON = 2'd0;
   localparam logic [1:0] CAUSE_SOFTWARE = 2'd1;
   localparam logic [1:0] CAUSE_WATCHDOG = 2'd2;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_ASSERT,
      ST_RELEASE,
      ST_RUN
   } state_t;

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_done;

   state_t                 state;
   state_t                 state_next;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_next;
   logic [WDT_WIDTH-1:0]   wdt_cnt;
   logic [WDT_WIDTH-1:0]   wdt_cnt_next;

   logic [CHANNELS-1:0]    rst_q;
   logic [CHANNELS-1:0]    rst_next;
   logic                   all_rel_q;
   logic                   all_rel_next;
   logic                   fired_q;
   logic                   fired_next;
   logic [1:0]             cause_q;
   logic [1:0]             cause_next;

   logic [CNT_W-1:0]       rel_cnt;
   logic [CHANNELS-1:0]    rel_mask;
   logic                   wdt_expire;
   logic                   sw_accept;

   // Board reset synchronizer. Assertion is asynchronous (every stage is set
   // at once), deassertion walks a zero through the chain one edge per stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_ff <= '1;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b0};
      end
   end

   // The last synchronizer stage is still set but the one before it is
   // already clear, so the synchronized reset drops on this very edge. The
   // sequence starts on that edge, which keeps the first release exactly
   // SYNC_STAGES + HOLD_CYCLES edges after the board reset rises.
   always_comb begin
      sync_done = sync_ff[SYNC_STAGES-1] & ~sync_ff[SYNC_STAGES-2];
   end

   // Value the sequence counter takes on this edge inside the release phase.
   // Leaving the hold phase restarts it at 0, so channels whose release
   // offset is 0 drop on that same edge.
   always_comb begin
      rel_cnt = '0;
      if (state == ST_RELEASE) begin
         rel_cnt = cnt + CNT_W'(1);
      end
   end

   // Channels whose scheduled release offset equals the counter value
   // produced by this edge. Channels released earlier are kept clear by
   // ANDing with the current outputs in the release phase.
   always_comb begin
      rel_mask = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         rel_mask[k] = (rel_cnt == CNT_W'(k * STAGGER));
      end
   end

   // Watchdog expiry: a kick in the same cycle always wins, and a zero limit
   // turns expiry off entirely while still letting the counter run.
   always_comb begin
      wdt_expire = bus.wdt_enable & ~bus.wdt_kick & (bus.wdt_limit != '0) &
                   (wdt_cnt == bus.wdt_limit - WDT_WIDTH'(1));
   end

   // Software requests only count once the hold phase is over; during the
   // synchronizer and hold phases they are dropped so the hold time is
   // never stretched.
   always_comb begin
      sw_accept = bus.sw_reset_req & ((state == ST_RELEASE) || (state == ST_RUN));
   end

   // Next-state and next-output logic. Every output is computed here and
   // registered below. The watchdog counter defaults to 0 so it is held at
   // zero in every state except RUN. A software request overrides a
   // watchdog expiry detected in the same cycle.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      wdt_cnt_next = '0;
      rst_next     = rst_q;
      cause_next   = cause_q;
      fired_next   = 1'b0;

      case (state)
         ST_SYNC: begin
            rst_next = '1;
            if (sync_done) begin
               state_next = ST_ASSERT;
               cnt_next   = '0;
               cause_next = CAUSE_POWER_ON;
            end
         end

         ST_ASSERT: begin
            rst_next = '1;
            if (cnt == HOLD_END) begin
               cnt_next   = '0;
               rst_next   = ~rel_mask;
               state_next = rel_mask[CHANNELS-1] ? ST_RUN : ST_RELEASE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            cnt_next = rel_cnt;
            rst_next = rst_q & ~rel_mask;
            if (rel_mask[CHANNELS-1]) begin
               state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            rst_next     = '0;
            wdt_cnt_next = wdt_cnt;
            if (bus.wdt_kick) begin
               wdt_cnt_next = '0;
            end else if (wdt_expire) begin
               state_next   = ST_ASSERT;
               cnt_next     = '0;
               wdt_cnt_next = '0;
               rst_next     = '1;
               cause_next   = CAUSE_WATCHDOG;
               fired_next   = 1'b1;
            end else if (bus.wdt_enable) begin
               wdt_cnt_next = wdt_cnt + WDT_WIDTH'(1);
            end
         end

         default: begin
            state_next = ST_SYNC;
            rst_next   = '1;
         end
      endcase

      if (sw_accept) begin
         state_next   = ST_ASSERT;
         cnt_next     = '0;
         wdt_cnt_next = '0;
         rst_next     = '1;
         cause_next   = CAUSE_SOFTWARE;
         fired_next   = 1'b0;
      end
   end

   // all_released is registered from the same next value as rst_out so the
   // two always change together.
   always_comb begin
      all_rel_next = (rst_next == '0);
   end

   // State, counters and registered outputs. The board reset forces every
   // channel reset high immediately, without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_SYNC;
         cnt       <= '0;
         wdt_cnt   <= '0;
         rst_q     <= '1;
         all_rel_q <= 1'b0;
         fired_q   <= 1'b0;
         cause_q   <= CAUSE_POWER_ON;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         wdt_cnt   <= wdt_cnt_next;
         rst_q     <= rst_next;
         all_rel_q <= all_rel_next;
         fired_q   <= fired_next;
         cause_q   <= cause_next;
      end
   end

   assign bus.rst_out      = rst_q;
   assign bus.all_released = all_rel_q;
   assign bus.wdt_fired    = fired_q;
   assign bus.cause        = cause_q;

endmodule

// File: tb/tb_mini16_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_mini16_reset_seq
//
// Bench for mini16_reset_seq. One instance uses the default parameters and
// is driven by every test; a second instance with STAGGER = 0 shares the
// board reset and is checked during power-on only. The reference model
// tracks the sequence as an age in cycles since the last sequence start and
// derives each channel from its release time HOLD + k*STAGGER.
// ---------------------------------------------------------------------------
module tb_mini16_reset_seq;

   localparam int CH      = 4;
   localparam int HOLD    = 10;
   localparam int STAG    = 4;
   localparam int SYNC    = 2;
   localparam int WW      = 16;
   localparam int RUN_AGE = HOLD + (CH - 1) * STAG;
   localparam int NVEC    = 12;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   mini16_reset_seq_if #(.CHANNELS(CH), .WDT_WIDTH(WW)) bus ();
   mini16_reset_seq_if #(.CHANNELS(CH), .WDT_WIDTH(WW)) bus0 ();

   mini16_reset_seq #(
      .CHANNELS(CH), .HOLD_CYCLES(HOLD), .STAGGER(STAG),
      .SYNC_STAGES(SYNC), .WDT_WIDTH(WW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   mini16_reset_seq #(
      .CHANNELS(CH), .HOLD_CYCLES(HOLD), .STAGGER(0),
      .SYNC_STAGES(SYNC), .WDT_WIDTH(WW)
   ) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state.
   bit         m_pre   = 1'b1;
   int         m_edges = 0;
   int         m_age   = 0;
   int         m_w     = 0;
   logic [1:0] m_cause = 2'd0;
   logic       m_fired = 1'b0;

   typedef struct {
      int       edge_no;
      logic [3:0] rst;
      logic       all_rel;
      logic [3:0] rst0;
      logic       all_rel0;
   } vec_t;

   vec_t vecs [NVEC];

   task automatic check_val(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_pre   = 1'b1;
      m_edges = 0;
      m_age   = 0;
      m_w     = 0;
      m_cause = 2'd0;
      m_fired = 1'b0;
   endtask

   // One rising edge of the model, using the inputs that are stable at it.
   task automatic model_step();
      bit past_hold;
      bit running;
      bit expire;
      int w_n;
      int lim;
      if (m_pre) begin
         m_edges++;
         m_fired = 1'b0;
         if (m_edges == SYNC) begin
            m_pre   = 1'b0;
            m_age   = 0;
            m_cause = 2'd0;
         end
      end else begin
         past_hold = (m_age >= HOLD);
         running   = (m_age >= RUN_AGE);
         expire    = 1'b0;
         w_n       = m_w;
         lim       = int'(bus.wdt_limit);
         if (running) begin
            if (bus.wdt_kick) w_n = 0;
            else if (bus.wdt_enable) begin
               if (lim != 0 && m_w == lim - 1) expire = 1'b1;
               else w_n = m_w + 1;
            end
         end
         if (bus.sw_reset_req && past_hold) begin
            m_age = 0; m_cause = 2'd1; m_w = 0; m_fired = 1'b0;
         end else if (expire) begin
            m_age = 0; m_cause = 2'd2; m_w = 0; m_fired = 1'b1;
         end else begin
            if (m_age < 1000000) m_age++;
            m_fired = 1'b0;
            m_w     = running ? w_n : 0;
         end
      end
   endtask

   function automatic logic [CH-1:0] model_rst();
      logic [CH-1:0] r;
      for (int k = 0; k < CH; k++) begin
         r[k] = m_pre || (m_age < HOLD + k * STAG);
      end
      return r;
   endfunction

   task automatic applyStimulus(input logic sw, input logic en, input logic kick,
                                input logic [WW-1:0] limit);
      bus.sw_reset_req = sw;
      bus.wdt_enable   = en;
      bus.wdt_kick     = kick;
      bus.wdt_limit    = limit;
   endtask

   task automatic checkOutput();
      check_val("rst_out", bus.rst_out, model_rst());
      check_val("all_released", bus.all_released, !m_pre && (m_age >= RUN_AGE));
      check_val("wdt_fired", bus.wdt_fired, m_fired);
      check_val("cause", bus.cause, m_cause);
   endtask

   // Advance one clock: model follows the edge, outputs are compared at the
   // falling edge, and the caller drives new inputs afterwards.
   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      else model_reset();
      @(negedge clk);
      checkOutput();
   endtask

   // Drop the board reset between edges and check the outputs change
   // before the next rising edge arrives.
   task automatic async_drop(input string tag);
      #2 reset = 1'b0;
      model_reset();
      #1;
      check_val({tag, "_rst_async"}, bus.rst_out, 4'hF);
      check_val({tag, "_cause_async"}, bus.cause, 2'd0);
      check_val({tag, "_allrel_async"}, bus.all_released, 1'b0);
      checkOutput();
   endtask

   initial begin
      int n;
      int vi;
      int fires;

      vecs[0]  = '{1,  4'hF, 1'b0, 4'hF, 1'b0};
      vecs[1]  = '{2,  4'hF, 1'b0, 4'hF, 1'b0};
      vecs[2]  = '{11, 4'hF, 1'b0, 4'hF, 1'b0};
      vecs[3]  = '{12, 4'hE, 1'b0, 4'h0, 1'b1};
      vecs[4]  = '{15, 4'hE, 1'b0, 4'h0, 1'b1};
      vecs[5]  = '{16, 4'hC, 1'b0, 4'h0, 1'b1};
      vecs[6]  = '{19, 4'hC, 1'b0, 4'h0, 1'b1};
      vecs[7]  = '{20, 4'h8, 1'b0, 4'h0, 1'b1};
      vecs[8]  = '{23, 4'h8, 1'b0, 4'h0, 1'b1};
      vecs[9]  = '{24, 4'h0, 1'b1, 4'h0, 1'b1};
      vecs[10] = '{25, 4'h0, 1'b1, 4'h0, 1'b1};
      vecs[11] = '{26, 4'h0, 1'b1, 4'h0, 1'b1};

      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      bus0.sw_reset_req = 1'b0;
      bus0.wdt_enable   = 1'b0;
      bus0.wdt_kick     = 1'b0;
      bus0.wdt_limit    = '0;

      // Power-on: reset low for 5 cycles, then the table of release points.
      async_drop("por");
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      vi = 0;
      for (int e = 1; e <= 26; e++) begin
         tick();
         if (vi < NVEC && vecs[vi].edge_no == e) begin
            check_val($sformatf("por_rst_e%0d", e), bus.rst_out, vecs[vi].rst);
            check_val($sformatf("por_all_e%0d", e), bus.all_released, vecs[vi].all_rel);
            check_val($sformatf("stag0_rst_e%0d", e), bus0.rst_out, vecs[vi].rst0);
            check_val($sformatf("stag0_all_e%0d", e), bus0.all_released, vecs[vi].all_rel0);
            vi++;
         end
      end
      check_val("por_cause", bus.cause, 2'd0);

      // Watchdog expiry with limit 5.
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd5);
      n = 0;
      do begin tick(); n++; end while (!bus.wdt_fired && n < 40);
      check_val("wdt_fire_latency", n, 5);
      check_val("wdt_rst_on_fire", bus.rst_out, 4'hF);
      check_val("wdt_cause", bus.cause, 2'd2);
      n = 0;
      do begin tick(); n++; end while (bus.rst_out[0] && n < 40);
      check_val("wdt_rerelease_bit0", n, 10);
      while (!bus.all_released && n < 60) begin tick(); n++; end
      check_val("wdt_rerelease_all", n, 22);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd5);

      // Kick on the cycle the counter sits at limit-1, then periodic kicks.
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd5);
      for (int i = 0; i < 4; i++) tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd5);
      tick();
      check_val("kick_prio_fired", bus.wdt_fired, 1'b0);
      check_val("kick_prio_rst", bus.rst_out, 4'h0);
      fires = 0;
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'b0, 1'b1, (i % 4) == 3, 16'd5);
         tick();
         if (bus.wdt_fired) fires++;
      end
      check_val("kick_no_fire", fires, 0);
      check_val("kick_still_run", bus.all_released, 1'b1);

      // Software request on the expiry cycle wins over the watchdog.
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd5);
      for (int i = 0; i < 4; i++) tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 16'd5);
      tick();
      check_val("sw_vs_wdt_cause", bus.cause, 2'd1);
      check_val("sw_vs_wdt_fired", bus.wdt_fired, 1'b0);
      check_val("sw_vs_wdt_rst", bus.rst_out, 4'hF);

      // Software request during the hold does not extend it.
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd5);
      n = 0;
      for (int i = 0; i < 3; i++) begin tick(); n++; end
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd5);
      tick(); n++;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd5);
      while (bus.rst_out[0] && n < 40) begin tick(); n++; end
      check_val("sw_in_hold_release", n, 10);

      // Abort mid-release with rst_out = 1100, then a full rerun.
      n = 0;
      while (bus.rst_out !== 4'hC && n < 30) begin tick(); n++; end
      check_val("abort_reached_1100", bus.rst_out, 4'hC);
      async_drop("abort");
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      n = 0;
      do begin tick(); n++; end while (bus.rst_out[0] && n < 40);
      check_val("abort_rerun_bit0", n, 12);
      while (!bus.all_released && n < 60) begin tick(); n++; end
      check_val("abort_rerun_all", n, 24);
      check_val("abort_rerun_cause", bus.cause, 2'd0);

      // Randomized traffic against the model.
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd12);
      for (int i = 0; i < 4000; i++) begin
         logic [WW-1:0] lim;
         lim = bus.wdt_limit;
         if ((i % 250) == 0) begin
            lim = ($urandom_range(0, 5) == 0) ? '0 : WW'($urandom_range(3, 30));
         end
         applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 9) != 0,
                       $urandom_range(0, 11) == 0, lim);
         if ($urandom_range(0, 599) == 0) begin
            async_drop("rand");
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) tick();
            reset = 1'b1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
